// File: rtl/calc_pkg.sv
// Shared constants for the sequential calculator ALU: opcodes,
// FSM state encoding and the default operand width.
package calc_pkg;

   localparam int CALC_W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_e;

endpackage

// File: rtl/calc_iter_muldiv.sv
// Iterative MUL/DIV datapath: one shift-add or restoring step per
// cycle over W cycles, sharing one hi/lo shift register pair.
// Ports: start/mode_div/a/b load, step advances, res = {hi,lo}
// after the current step (product, or {remainder, quotient}),
// last flags the final step.
module calc_iter_muldiv
   import calc_pkg::*;
#(
   parameter int W = CALC_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           mode_div,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           step,
   output logic [2*W-1:0] res,
   output logic           last
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          div_q, div_d;

   logic [W:0]    sum;
   logic [W:0]    trial;
   logic [W-1:0]  hi_s, lo_s;

   // hi holds partial product / partial remainder, lo holds the
   // multiplier (shifted out LSB first) or dividend/quotient.
   always_comb begin
      sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
      trial = {hi_q, lo_q[W-1]} - {1'b0, dvs_q};
      if (div_q) begin
         if (!trial[W]) begin
            hi_s = trial[W-1:0];
            lo_s = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_s = {hi_q[W-2:0], lo_q[W-1]};
            lo_s = {lo_q[W-2:0], 1'b0};
         end
      end else begin
         hi_s = sum[W:1];
         lo_s = {sum[0], lo_q[W-1:1]};
      end
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      div_d = div_q;
      if (start) begin
         hi_d  = '0;
         lo_d  = a;
         dvs_d = b;
         cnt_d = CW'(W - 1);
         div_d = mode_div;
      end else if (step) begin
         hi_d = hi_s;
         lo_d = lo_s;
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   assign res  = {hi_s, lo_s};
   assign last = (cnt_q == '0);

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU: IDLE/EXEC/DONE FSM, ADD/SUB, errors,
// iterative MUL/DIV. Ports: A/B/op/do_compute in; result, rem, neg,
// err_dz, err_op, busy, done out. Macro CALC_ALU_MOD_EN adds MOD.
module calc_alu_seq
   import calc_pkg::*;
#(
   parameter int W = CALC_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [2:0]     op,
   input  logic           do_compute,
   output logic [2*W-1:0] result,
   output logic [W-1:0]   rem,
   output logic           neg,
   output logic           err_dz,
   output logic           err_op,
   output logic           busy,
   output logic           done
);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]     op_q, op_d;
   logic [2*W-1:0] res_q, res_d;
   logic [W-1:0]   rem_q, rem_d;
   logic           neg_q, neg_d;
   logic           dz_q, dz_d;
   logic           eop_q, eop_d;

   logic           start, step, last;
   logic [2*W-1:0] res_md;
   logic           is_add, is_sub, is_mul, is_div, is_mod;
   logic           is_dv, bz, multi;
   logic [W:0]     sum, diff;
   logic [2*W-1:0] n_res;
   logic [W-1:0]   n_rem;
   logic           n_neg, n_dz, n_eop;

   assign is_add = (op_q == OP_ADD);
   assign is_sub = (op_q == OP_SUB);
   assign is_mul = (op_q == OP_MUL);
   assign is_div = (op_q == OP_DIV);
`ifdef CALC_ALU_MOD_EN
   assign is_mod = (op_q == OP_MOD);
`else
   assign is_mod = 1'b0;
`endif
   assign is_dv = is_div | is_mod;
   assign bz    = (b_q == '0);
   // Divide by zero short-circuits to a single EXEC cycle.
   assign multi = is_mul | (is_dv & !bz);

   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign diff = {1'b0, a_q} - {1'b0, b_q};

   calc_iter_muldiv #(.W(W)) u_iter (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode_div (op != OP_MUL),
      .a        (A),
      .b        (B),
      .step     (step),
      .res      (res_md),
      .last     (last)
   );

   always_comb begin
      n_res = '0;
      n_rem = '0;
      n_neg = 1'b0;
      n_dz  = 1'b0;
      n_eop = 1'b0;
      unique case (1'b1)
         is_add: n_res = {{(W-1){1'b0}}, sum};
         is_sub: begin
            n_res = {{(W-1){diff[W]}}, diff};
            n_neg = diff[W];
         end
         is_mul: n_res = res_md;
         is_dv & bz: begin
            n_res = '1;
            n_rem = a_q;
            n_dz  = 1'b1;
         end
         is_div & !bz: begin
            n_res = {{W{1'b0}}, res_md[W-1:0]};
            n_rem = res_md[2*W-1:W];
         end
         is_mod & !bz: begin
            n_res = {{W{1'b0}}, res_md[2*W-1:W]};
            n_rem = res_md[2*W-1:W];
         end
         default: n_eop = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      rem_d   = rem_q;
      neg_d   = neg_q;
      dz_d    = dz_q;
      eop_d   = eop_q;
      start   = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (do_compute) begin
               start   = 1'b1;
               a_d     = A;
               b_d     = B;
               op_d    = op;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            step = multi;
            if (!multi || last) begin
               state_d = ST_DONE;
               res_d   = n_res;
               rem_d   = n_rem;
               neg_d   = n_neg;
               dz_d    = n_dz;
               eop_d   = n_eop;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         rem_q   <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
         eop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         rem_q   <= rem_d;
         neg_q   <= neg_d;
         dz_q    <= dz_d;
         eop_q   <= eop_d;
      end
   end

   assign result = res_q;
   assign rem    = rem_q;
   assign neg    = neg_q;
   assign err_dz = dz_q;
   assign err_op = eop_q;
   assign busy   = (state_q == ST_EXEC);
   assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq: cycle timing, results, flags,
// ignored start pulses and mid-operation reset.
module tb_calc_alu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  A, B;
   logic [2:0]  op;
   logic        do_compute;
   logic [15:0] result;
   logic [7:0]  rem;
   logic        neg, err_dz, err_op, busy, done;

   int n_chk  = 0;
   int n_pass = 0;

   int dcyc, bcnt, bfirst, extra;

   calc_alu_seq dut (
      .clk        (clk),
      .reset      (reset),
      .A          (A),
      .B          (B),
      .op         (op),
      .do_compute (do_compute),
      .result     (result),
      .rem        (rem),
      .neg        (neg),
      .err_dz     (err_dz),
      .err_op     (err_op),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Cycle 0 = negedge where do_compute is raised. Inputs are
   // scrambled after accept; an optional stray pulse at pulse_at.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] o, input int pulse_at,
                         output int dc, output int bc, output int bf);
      @(negedge clk);
      A = a;
      B = b;
      op = o;
      do_compute = 1'b1;
      dc = -1;
      bc = 0;
      bf = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         do_compute = (c == pulse_at);
         if (c == 1) begin
            A = ~a;
            B = ~b;
            op = o ^ 3'b001;
         end
         if (busy) begin
            bc++;
            if (bf < 0) bf = c;
         end
         if (done) begin
            dc = c;
            break;
         end
      end
      do_compute = 1'b0;
      if (dc < 0) chk("timeout", 32'(dc), 32'd0);
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   initial begin
      reset = 1'b1;
      A = '0;
      B = '0;
      op = '0;
      do_compute = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_flags", {27'd0, rem == 0, neg, err_dz, err_op, busy},
          32'h10);
      chk("rst_done", 32'(done), 32'h0);

      run_op(8'd200, 8'd100, 3'b000, 0, dcyc, bcnt, bfirst);
      chk("add_done_cyc", 32'(dcyc), 32'd2);
      chk("add_busy_cnt", 32'(bcnt), 32'd1);
      chk("add_busy_first", 32'(bfirst), 32'd1);
      chk("add_result", 32'(result), 32'h012C);
      chk("add_neg", 32'(neg), 32'h0);

      run_op(8'd5, 8'd9, 3'b001, 0, dcyc, bcnt, bfirst);
      chk("sub_lt_result", 32'(result), 32'hFFFC);
      chk("sub_lt_neg", 32'(neg), 32'h1);
      chk("sub_done_cyc", 32'(dcyc), 32'd2);

      run_op(8'd9, 8'd5, 3'b001, 0, dcyc, bcnt, bfirst);
      chk("sub_gt_result", 32'(result), 32'h0004);
      chk("sub_gt_neg", 32'(neg), 32'h0);

      run_op(8'd255, 8'd255, 3'b010, 4, dcyc, bcnt, bfirst);
      chk("mul_done_cyc", 32'(dcyc), 32'd9);
      chk("mul_busy_cnt", 32'(bcnt), 32'd8);
      chk("mul_result", 32'(result), 32'hFE01);
      chk("mul_rem", 32'(rem), 32'h0);
      count_done(12, extra);
      chk("mul_extra_done", 32'(extra), 32'd0);

      run_op(8'd3, 8'd4, 3'b010, 0, dcyc, bcnt, bfirst);
      chk("mul_small", 32'(result), 32'h000C);

      run_op(8'd200, 8'd7, 3'b011, 0, dcyc, bcnt, bfirst);
      chk("div_done_cyc", 32'(dcyc), 32'd9);
      chk("div_result", 32'(result), 32'h001C);
      chk("div_rem", 32'(rem), 32'd4);
      chk("div_dz", 32'(err_dz), 32'h0);

      run_op(8'd13, 8'd0, 3'b011, 0, dcyc, bcnt, bfirst);
      chk("dz_done_cyc", 32'(dcyc), 32'd2);
      chk("dz_result", 32'(result), 32'hFFFF);
      chk("dz_rem", 32'(rem), 32'd13);
      chk("dz_flag", 32'(err_dz), 32'h1);
      chk("dz_errop", 32'(err_op), 32'h0);

      // MUL 3x4 with reset raised in cycle 5
      @(negedge clk);
      A = 8'd3;
      B = 8'd4;
      op = 3'b010;
      do_compute = 1'b1;
      @(negedge clk);
      do_compute = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_result", 32'(result), 32'h0);
      chk("rst_mid_rem", 32'(rem), 32'h0);
      chk("rst_mid_flags", {29'd0, neg, err_dz, err_op}, 32'h0);
      count_done(12, extra);
      chk("rst_mid_nodone", 32'(extra), 32'd0);

      run_op(8'd1, 8'd1, 3'b000, 0, dcyc, bcnt, bfirst);
      chk("post_rst_add", 32'(result), 32'h0002);

      run_op(8'd200, 8'd7, 3'b111, 0, dcyc, bcnt, bfirst);
      chk("ill_done_cyc", 32'(dcyc), 32'd2);
      chk("ill_errop", 32'(err_op), 32'h1);
      chk("ill_result", 32'(result), 32'h0);

      run_op(8'd200, 8'd7, 3'b100, 0, dcyc, bcnt, bfirst);
`ifdef CALC_ALU_MOD_EN
      chk("mod_result", 32'(result), 32'd4);
      chk("mod_rem", 32'(rem), 32'd4);
      chk("mod_errop", 32'(err_op), 32'h0);
      chk("mod_done_cyc", 32'(dcyc), 32'd9);
`else
      chk("op100_errop", 32'(err_op), 32'h1);
      chk("op100_result", 32'(result), 32'h0);
      chk("op100_rem", 32'(rem), 32'h0);
      chk("op100_done_cyc", 32'(dcyc), 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
